fetch_unit: RTL and testbench

Instruction-fetch stage of the multicycle 16-bit RISC datapath. It holds the program counter, fetches one instruction per pass through instruction memory over a req/ack handshake, and latches it into the instruction register. It also drives the current PC to the branch-target adder and selects the next PC from PC+2, the adder's result, a jump target or a return address when the control unit commands a PC write.

---
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, req/ack instruction fetch into IR, and next-PC select
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    input  logic        pc_write,
    input  logic [1:0]  pc_src,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    input  logic [15:0] ret_addr,
    output logic        fault
);
    typedef enum logic [1:0] {IDLE, REQ, EXEC, FAULT} state_e;

    state_e      state_q;
    logic [15:0] pc_q, ir_q, next_pc_d;
    logic        ir_valid_q, fault_q;

    always_comb begin
        pc_plus2  = pc_q + 16'd2;
        next_pc_d = pc_src == 2'b00 ? pc_plus2 :
                    pc_src == 2'b01 ? branch_target :
                    pc_src == 2'b10 ? jump_target : ret_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            ir_valid_q <= 1'b0;
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: if (imem_ack) begin
                    ir_q       <= imem_data;
                    ir_valid_q <= 1'b1;
                    state_q    <= EXEC;
                end
                EXEC: if (pc_write) begin
                    // an odd target is never fetched: the PC keeps its old value
                    if (next_pc_d[0]) begin
                        fault_q <= 1'b1;
                        state_q <= FAULT;
                    end else begin
                        pc_q    <= next_pc_d;
                        state_q <= REQ;
                    end
                end
                FAULT: state_q <= FAULT;
            endcase
        end
    end

    assign imem_req  = state_q == REQ;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign fault     = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan sequences plus random cycles against a behavioural model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, imem_ack, pc_write;
    logic [15:0] imem_data, branch_target, jump_target, ret_addr;
    logic [1:0]  pc_src;
    logic        imem_req, ir_valid, fault;
    logic [15:0] imem_addr, ir, pc, pc_plus2;

    int tests = 0;
    int fails = 0;

    localparam int P_IDLE = 0, P_FETCH = 1, P_WAIT = 2, P_DEAD = 3;
    int          m_phase;
    logic [15:0] m_pc, m_ir;
    logic        m_val, m_fault;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .ir_valid(ir_valid),
        .pc(pc), .pc_plus2(pc_plus2), .pc_write(pc_write), .pc_src(pc_src),
        .branch_target(branch_target), .jump_target(jump_target),
        .ret_addr(ret_addr), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: drive inputs, advance the model by the behavioural rules, compare at negedge
    task automatic step(input logic r, input logic a, input logic [15:0] d, input logic w,
                        input logic [1:0] s, input logic [15:0] b, input logic [15:0] j,
                        input logic [15:0] t);
        logic [15:0] cand [4];
        logic [15:0] tgt, p2;
        rst = r; imem_ack = a; imem_data = d; pc_write = w; pc_src = s;
        branch_target = b; jump_target = j; ret_addr = t;
        @(posedge clk);
        cand = '{m_pc + 16'd2, b, j, t};
        tgt  = cand[s];
        if (r) begin
            m_pc = 16'h0000; m_ir = 16'h0000; m_val = 0; m_fault = 0; m_phase = P_IDLE;
        end else begin
            m_val = 0;
            if (m_phase == P_IDLE) m_phase = P_FETCH;
            else if (m_phase == P_FETCH && a) begin
                m_ir = d; m_val = 1; m_phase = P_WAIT;
            end else if (m_phase == P_WAIT && w) begin
                if (tgt[0]) begin m_fault = 1; m_phase = P_DEAD; end
                else begin m_pc = tgt; m_phase = P_FETCH; end
            end
        end
        @(negedge clk);
        p2 = m_pc + 16'd2;
        check("m_req", 16'(imem_req), 16'(m_phase == P_FETCH));
        check("m_addr", imem_addr, m_pc);
        check("m_pc", pc, m_pc);
        check("m_pc2", pc_plus2, p2);
        check("m_ir", ir, m_ir);
        check("m_irv", 16'(ir_valid), 16'(m_val));
        check("m_fault", 16'(fault), 16'(m_fault));
    endtask

    task automatic idle(input logic a, input logic [15:0] d);
        step(1'b0, a, d, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic pcw(input logic [1:0] s, input logic [15:0] b, input logic [15:0] j,
                       input logic [15:0] t);
        step(1'b0, 1'b0, 16'h0, 1'b1, s, b, j, t);
    endtask

    initial begin
        // reset and first fetch with two wait cycles
        step(1'b1, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
        check("rst_req", 16'(imem_req), 16'h0);
        check("rst_ir", ir, 16'h0000);
        idle(1'b0, 16'h0);
        check("first_req", 16'(imem_req), 16'h1);
        check("first_addr", imem_addr, 16'h0000);
        idle(1'b0, 16'h0);
        idle(1'b0, 16'h0);
        idle(1'b1, 16'h1234);
        check("first_ir", ir, 16'h1234);
        check("first_irv", 16'(ir_valid), 16'h1);
        idle(1'b0, 16'h0);
        check("irv_pulse", 16'(ir_valid), 16'h0);
        // sequential PC with zero-wait memory
        for (int i = 1; i <= 3; i++) begin
            pcw(2'b00, 16'h0, 16'h0, 16'h0);
            check("seq_req", 16'(imem_req), 16'h1);
            check("seq_addr", imem_addr, 16'(2 * i));
            idle(1'b1, 16'(16'hA000 + i));
        end
        // branch / jump / return selection
        pcw(2'b01, 16'h0040, 16'h0100, 16'h0006);
        check("br_addr", imem_addr, 16'h0040);
        idle(1'b1, 16'h1111);
        pcw(2'b10, 16'h0040, 16'h0100, 16'h0006);
        check("jmp_addr", imem_addr, 16'h0100);
        idle(1'b1, 16'h2222);
        pcw(2'b11, 16'h0040, 16'h0100, 16'h0006);
        check("ret_addr", imem_addr, 16'h0006);
        idle(1'b1, 16'h3333);
        // wrap-around at FFFE
        pcw(2'b10, 16'h0, 16'hFFFE, 16'h0);
        check("wrap_p2", pc_plus2, 16'h0000);
        idle(1'b1, 16'h4444);
        pcw(2'b00, 16'h0, 16'h0, 16'h0);
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_fault", 16'(fault), 16'h0);
        idle(1'b1, 16'h5555);
        // misaligned branch target
        pcw(2'b01, 16'h0041, 16'h0, 16'h0);
        check("mis_fault", 16'(fault), 16'h1);
        check("mis_pc", pc, 16'h0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hBEEF, 1'b1, 2'b00, 16'h0, 16'h0, 16'h0);
        check("mis_req", 16'(imem_req), 16'h0);
        check("mis_ir", ir, 16'h5555);
        step(1'b1, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
        check("mis_clr", 16'(fault), 16'h0);
        check("mis_rstpc", pc, 16'h0000);
        // ignored events, then reset mid-fetch
        idle(1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 2'b10, 16'h0, 16'h0200, 16'h0);
        check("ign_pw_req", pc, 16'h0000);
        step(1'b0, 1'b1, 16'h6789, 1'b1, 2'b10, 16'h0, 16'h0200, 16'h0);
        check("ign_pw_ack", pc, 16'h0000);
        check("ign_ir", ir, 16'h6789);
        idle(1'b1, 16'hAAAA);
        check("ign_ack", ir, 16'h6789);
        step(1'b1, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
        idle(1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h7777, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
        check("rstm_ir", ir, 16'h0000);
        check("rstm_irv", 16'(ir_valid), 16'h0);
        check("rstm_req", 16'(imem_req), 16'h0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] b, j, t;
            b = 16'($urandom); j = 16'($urandom); t = 16'($urandom);
            if ($urandom_range(7) != 0) begin b[0] = 0; j[0] = 0; t[0] = 0; end
            step($urandom_range(39) == 0, $urandom_range(1) == 1, 16'($urandom),
                 $urandom_range(1) == 1, 2'($urandom_range(3)), b, j, t);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
